// File: rtl/instr_mem_loader_pkg.sv
// instr_loader_pkg: shared states and constants for the instruction-memory boot loader.
package instr_loader_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK, S_FINISH, S_DONE, S_ERR
  } state_e;
  localparam int DEFAULT_DEPTH  = 256;
  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/instr_mem_loader_byte_assembler.sv
// byte_assembler: 4-byte MSB-first shift register that packs a byte stream into words.
// Ports: clk, reset (sync, active high), clr (restart packing), shift_en (byte accepted),
//   byte_in (stream byte), word (packed word, valid with word_complete),
//   word_complete (the byte being shifted in is the 4th of a word).
module byte_assembler
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_complete
);
  logic [23:0] sr_q, sr_d;
  logic [1:0]  cnt_q, cnt_d;
  always_comb begin
    sr_d  = clr ? 24'd0 : shift_en ? {sr_q[15:0], byte_in} : sr_q;
    cnt_d = clr ? 2'd0 : shift_en ? cnt_q + 2'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end
  // The 4th byte completes the word directly from the input so the write can be registered on that edge.
  assign word          = {sr_q, byte_in};
  assign word_complete = shift_en && (cnt_q == 2'(BYTES_PER_WORD - 1));
endmodule

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: boot-time byte-stream to instruction-memory writer that holds the CPU until the image is loaded.
// Ports: clk, reset (sync, active high), Start (begin load), ByteIn/ByteValid/ByteReady (byte handshake),
//   WrEn/WrAddr/WrData (memory write port, byte address), Busy, Done, Error, CpuHold (CPU reset hold).
// Build option: LOADER_CHECKSUM_EN adds a trailing 8-bit sum-of-data-bytes check (CHECK state).
module instr_mem_loader
  import instr_loader_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        WrEn,
  output logic [31:0] WrAddr,
  output logic [31:0] WrData,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic        CpuHold
);
  localparam logic [16:0] DEPTH_L = 17'(DEPTH);
  state_e              state_q, state_d;
  logic [15:0]         n_q, n_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                wr_en_q, wr_en_d;
  logic [31:0]         wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic                xfer, clr, word_complete, last_word;
  logic [31:0]         asm_word;
  state_e              after_data;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          sum_q, sum_d;
  assign after_data = S_CHECK;
`else
  assign after_data = S_FINISH;
`endif
  assign ByteReady = state_q inside {S_LEN_HI, S_LEN_LO, S_DATA, S_CHECK};
  assign Busy      = !(state_q inside {S_IDLE, S_DONE, S_ERR});
  assign Done      = state_q == S_DONE;
  assign Error     = state_q == S_ERR;
  assign CpuHold   = state_q != S_DONE;
  assign WrEn      = wr_en_q;
  assign WrAddr    = wr_addr_q;
  assign WrData    = wr_data_q;
  assign xfer      = ByteValid && ByteReady;
  assign clr       = Start && !Busy;
  assign last_word = {{(16-ADDR_W){1'b0}}, idx_q} == n_q - 16'd1;
  byte_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .clr          (clr),
    .shift_en     (xfer && state_q == S_DATA),
    .byte_in      (ByteIn),
    .word         (asm_word),
    .word_complete(word_complete)
  );
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
`ifdef LOADER_CHECKSUM_EN
    sum_d     = clr ? 8'd0 : (xfer && state_q == S_DATA) ? sum_q + ByteIn : sum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE, S_ERR: state_d = Start ? S_LEN_HI : state_q;
      S_LEN_HI: begin
        n_d     = xfer ? {ByteIn, 8'd0} : n_q;
        state_d = xfer ? S_LEN_LO : state_q;
      end
      S_LEN_LO: begin
        n_d     = xfer ? {n_q[15:8], ByteIn} : n_q;
        idx_d   = '0;
        state_d = !xfer ? state_q : (n_d == 16'd0 || {1'b0, n_d} > DEPTH_L) ? S_ERR : S_DATA;
      end
      S_DATA: begin
        if (word_complete) begin
          wr_en_d   = 1'b1;
          wr_data_d = asm_word;
          wr_addr_d = {{(30-ADDR_W){1'b0}}, idx_q, 2'b00};
          idx_d     = idx_q + 1'b1;
          state_d   = last_word ? after_data : state_q;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: state_d = !xfer ? state_q : (ByteIn == sum_q) ? S_FINISH : S_ERR;
`endif
      // Stay while the last write is still on the port so Done never precedes the final commit.
      S_FINISH: state_d = wr_en_q ? S_FINISH : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed self-checking bench with a write scoreboard built from the stream contents.
module tb_instr_mem_loader;
  logic        clk = 1'b0;
  logic        reset, Start, ByteValid;
  logic [7:0]  ByteIn;
  logic        ByteReady, WrEn, Busy, Done, Error, CpuHold;
  logic [31:0] WrAddr, WrData;
  int          checks = 0, failures = 0, cyc = 0, last_wr = 0, nwr = 0;
  logic [31:0] exp_a[$], exp_d[$], log_a[$], log_d[$];
  logic        prev_we = 1'b0;

  instr_mem_loader dut (
    .clk(clk), .reset(reset), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .ByteReady(ByteReady), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .Busy(Busy), .Done(Done), .Error(Error), .CpuHold(CpuHold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Every write must match the next word the stream model predicts, and last exactly one cycle.
  always begin
    @(posedge clk);
    #1;
    if (WrEn === 1'b1) begin
      nwr++;
      last_wr = cyc;
      log_a.push_back(WrAddr);
      log_d.push_back(WrData);
      if (exp_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %h data %h required no write", WrAddr, WrData);
      end else begin
        chk("wr_addr", WrAddr, exp_a.pop_front());
        chk("wr_data", WrData, exp_d.pop_front());
      end
      chk("wren_width", {31'd0, prev_we}, 32'd0);
    end
    if (reset !== 1'b1) begin
      chk("hold_vs_done", {31'd0, CpuHold}, {31'd0, !Done});
      chk("ready_implies_busy", {31'd0, ByteReady && !Busy}, 32'd0);
    end
    prev_we = WrEn;
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    ByteIn    = b;
    ByteValid = 1'b1;
    while (ByteReady !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (ByteReady !== 1'b1) chk("ready_timeout", {31'd0, ByteReady}, 32'd1);
    @(negedge clk);
    ByteValid = 1'b0;
  endtask

  task automatic pulse_start(input bit with_valid);
    ByteValid = with_valid;
    ByteIn    = 8'h00;
    Start     = 1'b1;
    if (with_valid) chk("ready_during_start", {31'd0, ByteReady}, 32'd0);
    @(negedge clk);
    Start = 1'b0;
    chk("ready_after_start", {31'd0, ByteReady}, 32'd1);
    chk("busy_after_start", {31'd0, Busy}, 32'd1);
    chk("hold_after_start", {31'd0, CpuHold}, 32'd1);
    chk("done_cleared", {31'd0, Done}, 32'd0);
    chk("error_cleared", {31'd0, Error}, 32'd0);
  endtask

  // Model: word i goes to byte address 4*i; checksum is the mod-256 sum of data bytes only.
  task automatic load_words(input logic [31:0] w[$], input bit gaps, input bit bad);
    logic [7:0]  sum = 8'd0;
    logic [15:0] n = 16'(w.size());
    logic [31:0] cur;
    foreach (w[i]) begin
      exp_a.push_back(32'(i * 4));
      exp_d.push_back(w[i]);
    end
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    foreach (w[i]) begin
      cur = w[i];
      for (int b = 3; b >= 0; b--) begin
        if (gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
        send_byte(cur[8*b +: 8]);
        sum = sum + cur[8*b +: 8];
      end
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(bad ? sum + 8'd1 : sum);
`else
    if (bad) sum = 8'd0;
`endif
  endtask

  task automatic wait_end();
    int t = 0;
    while (Done !== 1'b1 && Error !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (Done !== 1'b1 && Error !== 1'b1) chk("end_timeout", {31'd0, Done | Error}, 32'd1);
  endtask

  task automatic check_idle_reset();
    chk("rst_wren", {31'd0, WrEn}, 32'd0);
    chk("rst_wraddr", WrAddr, 32'd0);
    chk("rst_wrdata", WrData, 32'd0);
    chk("rst_ready", {31'd0, ByteReady}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_error", {31'd0, Error}, 32'd0);
    chk("rst_hold", {31'd0, CpuHold}, 32'd1);
  endtask

  task automatic expect_end(input string name, input bit done);
    chk({name, "_done"}, {31'd0, Done}, {31'd0, done});
    chk({name, "_error"}, {31'd0, Error}, {31'd0, !done});
    chk({name, "_hold"}, {31'd0, CpuHold}, {31'd0, !done});
    chk({name, "_busy"}, {31'd0, Busy}, 32'd0);
    chk({name, "_ready"}, {31'd0, ByteReady}, 32'd0);
    chk({name, "_pending"}, 32'(exp_a.size()), 32'd0);
  endtask

  initial begin
    int n0;
    logic [31:0] q[$];
    reset = 1'b1; Start = 1'b0; ByteValid = 1'b0; ByteIn = 8'h00;
    repeat (3) @(negedge clk);
    check_idle_reset();
    reset = 1'b0;
    @(negedge clk);
    check_idle_reset();

    // Basic two-word image; Start arrives together with the first header byte.
    pulse_start(1'b1);
    q = '{32'h00008020, 32'h20100078};
    load_words(q, 1'b0, 1'b0);
    wait_end();
    chk("done_latency", 32'(cyc - last_wr), 32'd2);
    expect_end("basic", 1'b1);
    chk("basic_nwr", 32'(nwr), 32'd2);
    chk("log0_addr", log_a[0], 32'h0);
    chk("log0_data", log_d[0], 32'h00008020);
    chk("log1_addr", log_a[1], 32'h4);
    chk("log1_data", log_d[1], 32'h20100078);

    // Zero-length header aborts with no writes; Start from DONE re-raises CpuHold.
    n0 = nwr;
    pulse_start(1'b0);
    send_byte(8'h00);
    send_byte(8'h00);
    wait_end();
    expect_end("len0", 1'b0);
    chk("len0_nwr", 32'(nwr - n0), 32'd0);

    // Oversize header 257 > DEPTH aborts; Start from ERR.
    pulse_start(1'b0);
    send_byte(8'h01);
    send_byte(8'h01);
    wait_end();
    expect_end("len257", 1'b0);
    chk("len257_nwr", 32'(nwr - n0), 32'd0);
    repeat (3) @(negedge clk);
    chk("err_sticky", {31'd0, Error}, 32'd1);

    // Three words with random valid gaps.
    n0 = nwr;
    pulse_start(1'b0);
    q = '{32'hDEADBEEF, 32'h01234567, 32'hA5A5005A};
    load_words(q, 1'b1, 1'b0);
    wait_end();
    expect_end("gaps", 1'b1);
    chk("gaps_nwr", 32'(nwr - n0), 32'd3);
    chk("gaps_last_addr", log_a[log_a.size()-1], 32'h8);
    chk("gaps_last_data", log_d[log_d.size()-1], 32'hA5A5005A);

    // Reset after six data bytes: only word 0 is written.
    n0 = nwr;
    pulse_start(1'b0);
    exp_a.push_back(32'h0);
    exp_d.push_back(32'h11223344);
    send_byte(8'h00); send_byte(8'h03);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_reset();
    repeat (3) @(negedge clk);
    chk("rst_nwr", 32'(nwr - n0), 32'd1);
    chk("rst_pending", 32'(exp_a.size()), 32'd0);
    check_idle_reset();
    pulse_start(1'b0);
    q = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
    load_words(q, 1'b0, 1'b0);
    wait_end();
    expect_end("reload", 1'b1);
    chk("reload_nwr", 32'(nwr - n0), 32'd4);

`ifdef LOADER_CHECKSUM_EN
    // Wrong checksum: both words land, then the load errors.
    n0 = nwr;
    pulse_start(1'b0);
    q = '{32'h00008020, 32'h20100078};
    load_words(q, 1'b0, 1'b1);
    wait_end();
    expect_end("badsum", 1'b0);
    chk("badsum_nwr", 32'(nwr - n0), 32'd2);
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end
endmodule
